dram_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port 512x32 data RAM (`dram_top`: req/gnt/we/be/addr/wdata in, rvalid/rdata out, one-cycle read latency) between `NUM_PORTS` requesters, for example the core LSU, DMA and debug.
- Presents one memory-side master port and `NUM_PORTS` identical slave ports using the same req/gnt/rvalid protocol.
- Routes each response back to the port whose request was accepted.
- Supports short locked sequences (read-modify-write, bursts) with a bounded hold time so no port starves.

---
 rtl/dram_arb_pkg.sv | 31 +++
 rtl/dram_rr_pick.sv | 40 ++++
 rtl/dram_arbiter.sv | 152 +++++++++++++++
 tb/tb_dram_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and constants for the data-RAM arbiter.
//   DRAM_*       geometry of the 512x32 data RAM
//   port_idx_t   requester index (up to 8 requesters)
//   dram_req_t   one memory request {we, be, addr, wdata}
//   lock_state_t state of the locked-sequence tracker
//   rr_next      round-robin successor of a port index
package dram_arb_pkg;

    localparam int DRAM_ADDR_W = 9;
    localparam int DRAM_DATA_W = 32;
    localparam int DRAM_BE_W   = 4;

    typedef logic [2:0] port_idx_t;

    typedef struct packed {
        logic                   we;
        logic [DRAM_BE_W-1:0]   be;
        logic [DRAM_ADDR_W-1:0] addr;
        logic [DRAM_DATA_W-1:0] wdata;
    } dram_req_t;

    typedef enum logic {
        LK_IDLE,
        LK_HELD
    } lock_state_t;

    function automatic port_idx_t rr_next(input port_idx_t idx, input int unsigned num_ports);
        return (32'(idx) == num_ports - 1) ? '0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/dram_rr_pick.sv
// dram_rr_pick: combinational rotating-priority picker.
//   elig    in  NUM_PORTS  eligible requesters
//   rr_ptr  in  3          highest-priority index this cycle
//   win_oh  out NUM_PORTS  one-hot winner (zero when nothing eligible)
//   win_idx out 3          winner index
//   any     out 1          at least one eligible requester
module dram_rr_pick
    import dram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] elig,
    input  port_idx_t            rr_ptr,
    output logic [NUM_PORTS-1:0] win_oh,
    output port_idx_t            win_idx,
    output logic                 any
);

    logic found;

    // Scan offsets from rr_ptr; the inner loop decodes the rotated index
    // so every select uses a loop constant.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned ofs = 0; ofs < NUM_PORTS; ofs++) begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                if (!found && elig[j] && (j == (32'(rr_ptr) + ofs) % NUM_PORTS)) begin
                    found     = 1'b1;
                    win_oh[j] = 1'b1;
                    win_idx   = port_idx_t'(j);
                end
            end
        end
    end

    assign any = |elig;

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter sharing the single-port data RAM
// between NUM_PORTS requesters, with bounded locked sequences.
//   clk, rst                          clock, synchronous active-high reset
//   p_req/p_lock/p_we/p_be/p_addr/p_wdata  per-port request channels (packed)
//   p_gnt                             one-hot grant, same cycle as request
//   p_rvalid/p_rdata                  routed response, rdata broadcast
//   m_req/m_we/m_be/m_addr/m_wdata    memory request channel
//   m_gnt/m_rvalid/m_rdata            memory accept and response
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int BE_W      = 4,
    parameter int LOCK_MAX  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        p_req,
    input  logic [NUM_PORTS-1:0]        p_lock,
    input  logic [NUM_PORTS-1:0]        p_we,
    input  logic [NUM_PORTS*BE_W-1:0]   p_be,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]        p_gnt,
    output logic [NUM_PORTS-1:0]        p_rvalid,
    output logic [DATA_W-1:0]           p_rdata,
    output logic                        m_req,
    output logic                        m_we,
    output logic [BE_W-1:0]             m_be,
    output logic [ADDR_W-1:0]           m_addr,
    output logic [DATA_W-1:0]           m_wdata,
    input  logic                        m_gnt,
    input  logic                        m_rvalid,
    input  logic [DATA_W-1:0]           m_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    lock_state_t          lock_state, lock_state_n;
    port_idx_t            rr_ptr, rr_ptr_n;
    port_idx_t            lock_owner, lock_owner_n;
    port_idx_t            resp_id, resp_id_n;
    logic [CNT_W-1:0]     lock_cnt, lock_cnt_n;
    logic                 resp_pend, resp_pend_n;

    logic [NUM_PORTS-1:0] owner_mask, elig, win_oh;
    port_idx_t            win_idx;
    logic                 win_any, owner_req, lock_live, grant, win_lock;

    always_comb begin
        owner_mask = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            owner_mask[i] = (lock_owner == port_idx_t'(i));
    end

    // A lock only masks the others while its owner is still requesting;
    // if the owner drops out, normal arbitration runs in the same cycle.
    assign owner_req = |(p_req & owner_mask);
    assign lock_live = (lock_state == LK_HELD) && owner_req;
    assign elig      = lock_live ? (p_req & owner_mask) : p_req;

    dram_rr_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_pick (
        .elig   (elig),
        .rr_ptr (rr_ptr),
        .win_oh (win_oh),
        .win_idx(win_idx),
        .any    (win_any)
    );

    assign m_req    = win_any & ~rst;
    assign grant    = m_req & m_gnt;
    assign p_gnt    = grant ? win_oh : '0;
    assign win_lock = |(p_lock & win_oh);
    assign p_rdata  = m_rdata;

    always_comb begin
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (win_oh[i]) begin
                m_we    = p_we[i];
                m_be    = p_be[i*BE_W +: BE_W];
                m_addr  = p_addr[i*ADDR_W +: ADDR_W];
                m_wdata = p_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        p_rvalid = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            p_rvalid[i] = m_rvalid & resp_pend & (resp_id == port_idx_t'(i)) & ~rst;
    end

    always_comb begin
        lock_state_n = lock_state;
        lock_owner_n = lock_owner;
        lock_cnt_n   = lock_cnt;
        rr_ptr_n     = rr_ptr;
        resp_pend_n  = grant;
        resp_id_n    = grant ? win_idx : resp_id;

        if ((lock_state == LK_HELD) && !owner_req) begin
            lock_state_n = LK_IDLE;
            lock_cnt_n   = '0;
        end

        if (grant) begin
            if (lock_live) begin
                // The grant that reaches LOCK_MAX, or one without p_lock, closes the lock.
                if (!win_lock || (lock_cnt == CNT_W'(LOCK_MAX - 1))) begin
                    lock_state_n = LK_IDLE;
                    lock_cnt_n   = '0;
                    rr_ptr_n     = rr_next(win_idx, NUM_PORTS);
                end else begin
                    lock_cnt_n = lock_cnt + 1'b1;
                end
            end else if (win_lock && (LOCK_MAX > 1)) begin
                lock_state_n = LK_HELD;
                lock_owner_n = win_idx;
                lock_cnt_n   = CNT_W'(1);
            end else begin
                rr_ptr_n = rr_next(win_idx, NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= LK_IDLE;
            lock_owner <= '0;
            lock_cnt   <= '0;
            rr_ptr     <= '0;
            resp_pend  <= 1'b0;
            resp_id    <= '0;
        end else begin
            lock_state <= lock_state_n;
            lock_owner <= lock_owner_n;
            lock_cnt   <= lock_cnt_n;
            rr_ptr     <= rr_ptr_n;
            resp_pend  <= resp_pend_n;
            resp_id    <= resp_id_n;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed bench for dram_arbiter with a 512x32
// one-cycle-latency RAM behind the memory port.
module tb_dram_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   p_req, p_lock, p_we;
    logic [15:0]  p_be;
    logic [35:0]  p_addr;
    logic [127:0] p_wdata;
    logic [3:0]   p_gnt, p_rvalid;
    logic [31:0]  p_rdata;
    logic         m_req, m_we, m_gnt;
    logic [3:0]   m_be;
    logic [8:0]   m_addr;
    logic [31:0]  m_wdata;
    logic         m_rvalid = 1'b0;
    logic [31:0]  m_rdata  = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dram_arbiter #(
        .NUM_PORTS(4),
        .ADDR_W   (9),
        .DATA_W   (32),
        .BE_W     (4),
        .LOCK_MAX (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .p_req   (p_req),
        .p_lock  (p_lock),
        .p_we    (p_we),
        .p_be    (p_be),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_gnt   (p_gnt),
        .p_rvalid(p_rvalid),
        .p_rdata (p_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_gnt   (m_gnt),
        .m_rvalid(m_rvalid),
        .m_rdata (m_rdata)
    );

    // RAM model: one-cycle latency, byte-enabled writes.
    logic [31:0] mem [512];
    logic [31:0] wtmp;
    always @(posedge clk) begin
        if (m_req && m_gnt) begin
            m_rvalid <= 1'b1;
            if (m_we) begin
                wtmp = mem[m_addr];
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) wtmp[b*8 +: 8] = m_wdata[b*8 +: 8];
                mem[m_addr] <= wtmp;
            end else begin
                m_rdata <= mem[m_addr];
            end
        end else begin
            m_rvalid <= 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int i, input logic we, input logic [3:0] be,
                            input logic [8:0] addr, input logic [31:0] data);
        p_we[i]              = we;
        p_be[i*4 +: 4]       = be;
        p_addr[i*9 +: 9]     = addr;
        p_wdata[i*32 +: 32]  = data;
    endtask

    // One cycle: drive requests, check grant/response at the falling edge,
    // then advance to just after the next rising edge.
    task automatic cyc(input logic [3:0] req, input logic [3:0] lock,
                       input logic [3:0] eg, input logic [3:0] erv,
                       input logic chk_rd, input logic [31:0] erd, input string tag);
        p_req  = req;
        p_lock = lock;
        @(negedge clk);
        check_val({tag, "_gnt"}, 32'(p_gnt), 32'(eg));
        check_val({tag, "_rvalid"}, 32'(p_rvalid), 32'(erv));
        if (chk_rd) check_val({tag, "_rdata"}, p_rdata, erd);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fc_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] lk_g [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                             4'b1000, 4'b0010, 4'b0010, 4'b0010};
    logic [3:0] prev;

    initial begin
        rst = 1'b1; p_req = 4'hF; p_lock = '0; p_we = '0; p_be = '0;
        p_addr = '0; p_wdata = '0; m_gnt = 1'b1;

        // Reset holds everything quiet even with all ports requesting.
        repeat (2) begin
            @(negedge clk);
            check_val("rst_gnt", 32'(p_gnt), 32'h0);
            check_val("rst_mreq", 32'(m_req), 32'h0);
            check_val("rst_rvalid", 32'(p_rvalid), 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Full contention: 0,1,2,3,0 with responses one cycle behind.
        prev = '0;
        for (int k = 0; k < 5; k++) begin
            cyc(4'hF, 4'h0, fc_g[k], prev, 1'b0, 32'h0, "rr");
            prev = fc_g[k];
        end
        cyc(4'h0, 4'h0, 4'h0, prev, 1'b0, 32'h0, "rr_tail");

        // Write from port 2, read back from port 1, then a byte write.
        set_port(2, 1'b1, 4'hF, 9'h1A5, 32'hDEADBEEF);
        p_req = 4'b0100;
        #1;
        check_val("wr_maddr", 32'(m_addr), 32'h1A5);
        check_val("wr_mwe", 32'(m_we), 32'h1);
        check_val("wr_mwdata", m_wdata, 32'hDEADBEEF);
        cyc(4'b0100, 4'h0, 4'b0100, 4'b0000, 1'b0, 32'h0, "wr2");
        set_port(1, 1'b0, 4'h0, 9'h1A5, 32'h0);
        cyc(4'b0010, 4'h0, 4'b0010, 4'b0100, 1'b0, 32'h0, "rd1");
        cyc(4'b0000, 4'h0, 4'b0000, 4'b0010, 1'b1, 32'hDEADBEEF, "rd1_resp");
        set_port(1, 1'b1, 4'b0001, 9'h1A5, 32'h55);
        cyc(4'b0010, 4'h0, 4'b0010, 4'b0000, 1'b0, 32'h0, "wrb1");
        set_port(1, 1'b0, 4'h0, 9'h1A5, 32'h0);
        cyc(4'b0010, 4'h0, 4'b0010, 4'b0010, 1'b0, 32'h0, "rdb1");
        cyc(4'b0000, 4'h0, 4'b0000, 4'b0010, 1'b1, 32'hDEADBE55, "rdb1_resp");
        set_port(2, 1'b0, 4'h0, 9'h0, 32'h0);

        // Reset to bring the pointer back to 0, then the lock bound.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            cyc(4'b1010, 4'b0010, lk_g[k], prev, 1'b0, 32'h0, "lock");
            prev = lk_g[k];
        end

        // Reset mid-lock suppresses the pending response.
        rst = 1'b1;
        @(negedge clk);
        check_val("rstlk_rvalid", 32'(p_rvalid), 32'h0);
        check_val("rstlk_mreq", 32'(m_req), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Backpressure: nothing moves while m_gnt is low.
        m_gnt = 1'b0;
        repeat (3) begin
            p_req = 4'b0101;
            #1;
            check_val("bp_mreq", 32'(m_req), 32'h1);
            cyc(4'b0101, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0, "bp_hold");
        end
        m_gnt = 1'b1;
        cyc(4'b0101, 4'h0, 4'b0001, 4'b0000, 1'b0, 32'h0, "bp_g0");
        cyc(4'b0101, 4'h0, 4'b0100, 4'b0001, 1'b0, 32'h0, "bp_g2");

        // Sparse requests: no idle slot, pointer wraps to 0 after port 3.
        cyc(4'b0001, 4'h0, 4'b0001, 4'b0100, 1'b0, 32'h0, "sp0");
        cyc(4'b1000, 4'h0, 4'b1000, 4'b0001, 1'b0, 32'h0, "sp3");
        cyc(4'b0011, 4'h0, 4'b0001, 4'b1000, 1'b0, 32'h0, "sp_ptr0");
        cyc(4'b0000, 4'h0, 4'b0000, 4'b0001, 1'b0, 32'h0, "sp_tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
